// File: rtl/enc424j600_reg_arb.sv
// Round-robin register-access arbiter for the ENC424J600 SPI master.
// Builds unbanked RCRU/WCRU 3-byte commands and returns one tagged response per request.
module enc424j600_reg_arb #(
  parameter logic [7:0]  RCRU_OP   = 8'h20,
  parameter logic [7:0]  WCRU_OP   = 8'h22,
  parameter logic [10:0] NBYTE_NUM = 11'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [7:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [7:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic [15:0] m_opbyte,
  output logic        m_opbyte_valid,
  output logic [10:0] m_nbyte_num,
  output logic [7:0]  m_wrdat_byte,
  output logic        m_wrdat_valid,
  input  logic        m_wrdat_ready,
  input  logic [7:0]  m_rddat_byte,
  input  logic        m_rddat_valid,
  input  logic        m_txn_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r, state_nxt;
  logic        last_grant_r, last_grant_nxt;
  logic        id_r, id_nxt;
  logic        write_r, write_nxt;
  logic [7:0]  addr_r, addr_nxt;
  logic [15:0] wdata_r, wdata_nxt;
  logic [15:0] rdata_r, rdata_nxt;
  logic [1:0]  wr_cnt_r, wr_cnt_nxt;
  logic [1:0]  rd_cnt_r, rd_cnt_nxt;

  logic        grant0, grant1, accept;
  logic        sel_write;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;

  logic [15:0] opbyte_nxt;
  logic        opbyte_valid_nxt;
  logic [7:0]  wrdat_byte_nxt;
  logic        wrdat_valid_nxt;
  logic        rsp_valid_nxt, rsp_id_nxt, rsp_write_nxt;
  logic [15:0] rsp_rdata_nxt;

  assign m_nbyte_num = NBYTE_NUM;

  // Round-robin pick: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_r;
      grant1 = ~last_grant_r;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign accept     = (state_r == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_r == IDLE) && grant0;
  assign req1_ready = (state_r == IDLE) && grant1;
  assign sel_write  = grant1 ? req1_write : req0_write;
  assign sel_addr   = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata  = grant1 ? req1_wdata : req0_wdata;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt        = state_r;
    last_grant_nxt   = last_grant_r;
    id_nxt           = id_r;
    write_nxt        = write_r;
    addr_nxt         = addr_r;
    wdata_nxt        = wdata_r;
    rdata_nxt        = rdata_r;
    wr_cnt_nxt       = wr_cnt_r;
    rd_cnt_nxt       = rd_cnt_r;
    opbyte_nxt       = m_opbyte;
    opbyte_valid_nxt = 1'b0;
    wrdat_byte_nxt   = m_wrdat_byte;
    wrdat_valid_nxt  = m_wrdat_valid;
    rsp_valid_nxt    = 1'b0;
    rsp_id_nxt       = rsp_id;
    rsp_write_nxt    = rsp_write;
    rsp_rdata_nxt    = rsp_rdata;
    case (state_r)
      IDLE: begin
        if (accept) begin
          id_nxt           = grant1;
          last_grant_nxt   = grant1;
          write_nxt        = sel_write;
          addr_nxt         = sel_addr;
          wdata_nxt        = sel_wdata;
          rdata_nxt        = 16'h0000;
          wr_cnt_nxt       = 2'd0;
          rd_cnt_nxt       = 2'd0;
          opbyte_nxt       = {sel_addr, (sel_write ? WCRU_OP : RCRU_OP)};
          opbyte_valid_nxt = 1'b1;
          state_nxt        = CMD;
        end else begin
          state_nxt = IDLE;
        end
      end
      CMD: begin
        wrdat_valid_nxt = write_r;
        wrdat_byte_nxt  = write_r ? wdata_r[7:0] : 8'h00;
        state_nxt       = XFER;
      end
      XFER: begin
        if (write_r && m_wrdat_valid && m_wrdat_ready) begin
          if (wr_cnt_r == 2'd0) begin
            wrdat_byte_nxt = wdata_r[15:8];
            wr_cnt_nxt     = 2'd1;
          end else begin
            wrdat_valid_nxt = 1'b0;
            wr_cnt_nxt      = 2'd2;
          end
        end else begin
          wr_cnt_nxt = wr_cnt_r;
        end
        // Read bytes arrive low byte first; anything past the second is dropped.
        if (!write_r && m_rddat_valid) begin
          case (rd_cnt_r)
            2'd0: begin
              rdata_nxt[7:0] = m_rddat_byte;
              rd_cnt_nxt     = 2'd1;
            end
            2'd1: begin
              rdata_nxt[15:8] = m_rddat_byte;
              rd_cnt_nxt      = 2'd2;
            end
            default: rd_cnt_nxt = rd_cnt_r;
          endcase
        end else begin
          rd_cnt_nxt = rd_cnt_r;
        end
        if (m_txn_done) begin
          wrdat_valid_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_id_nxt      = id_r;
          rsp_write_nxt   = write_r;
          rsp_rdata_nxt   = write_r ? 16'h0000 : rdata_nxt;
          state_nxt       = RESP;
        end else begin
          state_nxt = XFER;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      last_grant_r   <= 1'b1;
      id_r           <= 1'b0;
      write_r        <= 1'b0;
      addr_r         <= 8'h00;
      wdata_r        <= 16'h0000;
      rdata_r        <= 16'h0000;
      wr_cnt_r       <= 2'd0;
      rd_cnt_r       <= 2'd0;
      m_opbyte       <= 16'h0000;
      m_opbyte_valid <= 1'b0;
      m_wrdat_byte   <= 8'h00;
      m_wrdat_valid  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= 16'h0000;
    end else begin
      state_r        <= state_nxt;
      last_grant_r   <= last_grant_nxt;
      id_r           <= id_nxt;
      write_r        <= write_nxt;
      addr_r         <= addr_nxt;
      wdata_r        <= wdata_nxt;
      rdata_r        <= rdata_nxt;
      wr_cnt_r       <= wr_cnt_nxt;
      rd_cnt_r       <= rd_cnt_nxt;
      m_opbyte       <= opbyte_nxt;
      m_opbyte_valid <= opbyte_valid_nxt;
      m_wrdat_byte   <= wrdat_byte_nxt;
      m_wrdat_valid  <= wrdat_valid_nxt;
      rsp_valid      <= rsp_valid_nxt;
      rsp_id         <= rsp_id_nxt;
      rsp_write      <= rsp_write_nxt;
      rsp_rdata      <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_enc424j600_reg_arb.sv
// Self-checking bench for enc424j600_reg_arb: a scripted SPI-master model plus a
// round-robin/byte-assembly reference model, with randomized requests.
module tb_enc424j600_reg_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_write;
  logic [7:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [7:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp_valid, rsp_id, rsp_write;
  logic [15:0] rsp_rdata;
  logic [15:0] m_opbyte;
  logic        m_opbyte_valid;
  logic [10:0] m_nbyte_num;
  logic [7:0]  m_wrdat_byte;
  logic        m_wrdat_valid, m_wrdat_ready;
  logic [7:0]  m_rddat_byte;
  logic        m_rddat_valid, m_txn_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_last = 1'b1;

  always #5 clk = ~clk;

  enc424j600_reg_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .m_opbyte(m_opbyte), .m_opbyte_valid(m_opbyte_valid), .m_nbyte_num(m_nbyte_num),
    .m_wrdat_byte(m_wrdat_byte), .m_wrdat_valid(m_wrdat_valid), .m_wrdat_ready(m_wrdat_ready),
    .m_rddat_byte(m_rddat_byte), .m_rddat_valid(m_rddat_valid), .m_txn_done(m_txn_done)
  );

  task automatic drive_idle();
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 8'h00; req0_wdata = 16'h0000;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 8'h00; req1_wdata = 16'h0000;
    m_wrdat_ready = 1'b0; m_rddat_byte = 8'h00; m_rddat_valid = 1'b0; m_txn_done = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the CMD cycle.
  task automatic issue(input bit v0, input bit w0, input logic [7:0] a0, input logic [15:0] d0,
                       input bit v1, input bit w1, input logic [7:0] a1, input logic [15:0] d1,
                       input bit hold, output int who);
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    who = -1;
    if (req0_ready && !req1_ready) who = 0;
    else if (req1_ready && !req0_ready) who = 1;
    @(negedge clk);
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    req0_write = 1'($urandom); req0_addr = 8'($urandom); req0_wdata = 16'($urandom);
    req1_write = 1'($urandom); req1_addr = 8'($urandom); req1_wdata = 16'($urandom);
  endtask

  // SPI-master model: 8 XFER cycles, then txn_done; returns at the negedge after the response.
  task automatic run_txn(input bit is_wr, input int nrd, input int max_wr, input logic [23:0] rbytes,
                         output logic [15:0] op, output bit opv, output int extra,
                         output logic [15:0] wgot, output int wcnt,
                         output bit rv, output bit rid, output bit rwr, output logic [15:0] rdat,
                         output int glitch);
    op = m_opbyte; opv = m_opbyte_valid; extra = 0; wgot = 16'h0000; wcnt = 0; glitch = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_opbyte_valid) extra++;
      if (rsp_valid || req0_ready || req1_ready) glitch++;
      if (is_wr) begin
        if (wcnt < max_wr) m_wrdat_ready = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        else m_wrdat_ready = (max_wr >= 2);
        if (m_wrdat_valid && m_wrdat_ready) begin
          if (wcnt < 2) wgot[wcnt*8 +: 8] = m_wrdat_byte;
          wcnt++;
        end
        m_rddat_valid = 1'($urandom);
        m_rddat_byte = 8'($urandom);
      end else begin
        if (m_wrdat_valid) glitch++;
        m_rddat_valid = (k < nrd);
        m_rddat_byte = (k < nrd) ? rbytes[k*8 +: 8] : 8'h00;
      end
    end
    @(negedge clk);
    m_wrdat_ready = 1'b0; m_rddat_valid = 1'b0;
    if (rsp_valid || m_opbyte_valid) glitch++;
    m_txn_done = 1'b1;
    @(negedge clk);
    m_txn_done = 1'b0;
    rv = rsp_valid; rid = rsp_id; rwr = rsp_write; rdat = rsp_rdata;
    if (m_wrdat_valid) glitch++;
    @(negedge clk);
    if (rsp_valid) glitch++;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_opbyte_valid, m_opbyte, m_wrdat_valid, m_wrdat_byte, rsp_valid, rsp_id, rsp_write,
         rsp_rdata, req0_ready, req1_ready} !== 47'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got opv=%b op=%h wv=%b wb=%h rv=%b rd=%h want all 0",
               m_opbyte_valid, m_opbyte, m_wrdat_valid, m_wrdat_byte, rsp_valid, rsp_rdata);
    end
    n_cmp++;
    if (m_nbyte_num !== 11'd3) begin
      n_bad++;
      $display("FAIL reset_nbyte: got %0d want 3", m_nbyte_num);
    end
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int who, extra, wcnt, glitch;
    logic [15:0] op, wgot, rdat;
    bit opv, rv, rid, rwr;
    issue(1'b1, 1'b0, 8'h1E, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, who);
    run_txn(1'b0, 2, 0, 24'h001234, op, opv, extra, wgot, wcnt, rv, rid, rwr, rdat, glitch);
    n_cmp++;
    if (who !== 0 || op !== 16'h1E20 || opv !== 1'b1 || extra !== 0) begin
      n_bad++;
      $display("FAIL read_cmd: got who=%0d op=%h opv=%b extra=%0d want 0 1e20 1 0", who, op, opv, extra);
    end
    n_cmp++;
    if ({rv, rid, rwr, rdat} !== {1'b1, 1'b0, 1'b0, 16'h1234} || glitch !== 0) begin
      n_bad++;
      $display("FAIL read_rsp: got v=%b id=%b w=%b d=%h glitch=%0d want 1 0 0 1234 0", rv, rid, rwr, rdat, glitch);
    end
    model_last = 1'b0;
  endtask

  task automatic test_single_write();
    int who, extra, wcnt, glitch;
    logic [15:0] op, wgot, rdat;
    bit opv, rv, rid, rwr;
    issue(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h7E, 16'hBEEF, 1'b0, who);
    run_txn(1'b1, 0, 2, 24'h0, op, opv, extra, wgot, wcnt, rv, rid, rwr, rdat, glitch);
    n_cmp++;
    if (who !== 1 || op !== 16'h7E22 || opv !== 1'b1 || extra !== 0) begin
      n_bad++;
      $display("FAIL write_cmd: got who=%0d op=%h opv=%b extra=%0d want 1 7e22 1 0", who, op, opv, extra);
    end
    n_cmp++;
    if (wgot !== 16'hBEEF || wcnt !== 2) begin
      n_bad++;
      $display("FAIL write_bytes: got %h count=%0d want beef count=2", wgot, wcnt);
    end
    n_cmp++;
    if ({rv, rid, rwr, rdat} !== {1'b1, 1'b1, 1'b1, 16'h0000} || glitch !== 0) begin
      n_bad++;
      $display("FAIL write_rsp: got v=%b id=%b w=%b d=%h glitch=%0d want 1 1 1 0000 0", rv, rid, rwr, rdat, glitch);
    end
    model_last = 1'b1;
  endtask

  // Generic randomized transaction against the reference model.
  task automatic rand_txn(input string tag, input bit v0, input bit v1, input bit hold,
                          input int nrd, input int max_wr);
    int who, extra, wcnt, glitch, exp_who, exp_wcnt;
    logic [15:0] op, wgot, rdat, exp_rdat, exp_wgot;
    bit opv, rv, rid, rwr;
    bit w[2];
    logic [7:0] a[2];
    logic [15:0] d[2];
    logic [23:0] rb;
    for (int i = 0; i < 2; i++) begin
      w[i] = 1'($urandom); a[i] = 8'($urandom); d[i] = 16'($urandom);
    end
    rb = 24'($urandom);
    exp_who = (v0 && v1) ? (model_last ? 0 : 1) : (v0 ? 0 : 1);
    issue(v0, w[0], a[0], d[0], v1, w[1], a[1], d[1], hold, who);
    run_txn(w[exp_who], nrd, max_wr, rb, op, opv, extra, wgot, wcnt, rv, rid, rwr, rdat, glitch);
    exp_wcnt = !w[exp_who] ? 0 : (max_wr > 2 ? 2 : max_wr);
    exp_wgot = (exp_wcnt == 2) ? d[exp_who] : ((exp_wcnt == 1) ? {8'h00, d[exp_who][7:0]} : 16'h0000);
    exp_rdat = w[exp_who] ? 16'h0000 :
               (nrd >= 2 ? rb[15:0] : (nrd == 1 ? {8'h00, rb[7:0]} : 16'h0000));
    n_cmp++;
    if (who !== exp_who) begin
      n_bad++;
      $display("FAIL %s_grant: got %0d want %0d", tag, who, exp_who);
    end
    n_cmp++;
    if (op !== {a[exp_who], (w[exp_who] ? 8'h22 : 8'h20)} || opv !== 1'b1 || extra !== 0) begin
      n_bad++;
      $display("FAIL %s_cmd: got op=%h opv=%b extra=%0d want %h 1 0", tag, op, opv, extra,
               {a[exp_who], (w[exp_who] ? 8'h22 : 8'h20)});
    end
    n_cmp++;
    if (wgot !== exp_wgot || wcnt !== exp_wcnt) begin
      n_bad++;
      $display("FAIL %s_wbytes: got %h count=%0d want %h count=%0d", tag, wgot, wcnt, exp_wgot, exp_wcnt);
    end
    n_cmp++;
    if ({rv, rid, rwr, rdat} !== {1'b1, 1'(exp_who), w[exp_who], exp_rdat} || glitch !== 0) begin
      n_bad++;
      $display("FAIL %s_rsp: got v=%b id=%b w=%b d=%h glitch=%0d want 1 %0d %b %h 0",
               tag, rv, rid, rwr, rdat, glitch, exp_who, w[exp_who], exp_rdat);
    end
    model_last = 1'(exp_who);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) rand_txn("rr", 1'b1, 1'b1, 1'b1, 2, 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_req1_only();
    for (int i = 0; i < 3; i++) rand_txn("req1_only", 1'b0, 1'b1, 1'b1, 2, 2);
    req1_valid = 1'b0;
  endtask

  task automatic test_spurious();
    int bad = 0;
    m_txn_done = 1'b1; m_rddat_valid = 1'b1; m_rddat_byte = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      m_txn_done = 1'b0; m_rddat_valid = 1'b0;
      if (rsp_valid || m_opbyte_valid) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL idle_done: got %0d spurious pulses want 0", bad);
    end
    rand_txn("third_byte", 1'b1, 1'b0, 1'b0, 3, 2);
  endtask

  task automatic test_partial();
    rand_txn("part_w1", 1'b1, 1'b0, 1'b0, 0, 1);
    rand_txn("part_w0", 1'b0, 1'b1, 1'b0, 0, 0);
    rand_txn("part_r1", 1'b1, 1'b0, 1'b0, 1, 2);
    rand_txn("part_r0", 1'b0, 1'b1, 1'b0, 0, 2);
  endtask

  task automatic test_reset_mid();
    int who, bad;
    issue(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h55, 16'hA5C3, 1'b0, who);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({m_opbyte_valid, m_opbyte, m_wrdat_valid, m_wrdat_byte, rsp_valid, rsp_id, rsp_write,
         rsp_rdata, req0_ready, req1_ready} !== 47'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got opv=%b op=%h wv=%b wb=%h rv=%b want all 0",
               m_opbyte_valid, m_opbyte, m_wrdat_valid, m_wrdat_byte, rsp_valid);
    end
    model_last = 1'b1;
    bad = 0;
    m_txn_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      m_txn_done = 1'b0;
      if (rsp_valid) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_rsp: got %0d responses want 0", bad);
    end
    rand_txn("after_rst", 1'b1, 1'b1, 1'b0, 2, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      rand_txn("random", v0, v1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_req1_only();
    test_spurious();
    test_partial();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
